mm2axi4_bridge: RTL and testbench

MM2AXI4_BRIDGE -- requirements
Module: mm2axi4_bridge

---
 rtl/mm2axi4_pkg.sv | 33 +++
 rtl/mm2axi4_lane.sv | 35 +++
 rtl/mm2axi4_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_mm2axi4_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2axi4_pkg.sv
// Shared types and constants for the CPU-to-AXI4 single-beat bridge.
package mm2axi4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_EXOKAY   = 2'b01;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [1:0] RESP_DECERR   = 2'b11;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [2:0] SIZE_4B       = 3'b010;
   localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

   // Number of address bits that select a 32-bit lane within one data beat.
   function automatic int lane_bits(input int datalen);
      return (datalen >= 128) ? 2 : (datalen >= 64) ? 1 : 0;
   endfunction

   function automatic logic is_err(input logic [1:0] resp);
      logic e;
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   e = 1'b0;
         RESP_SLVERR, RESP_DECERR: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/mm2axi4_lane.sv
// Combinational lane steering: replicates write data, positions strobes, and
// extracts the addressed 32-bit word from a read beat.
module mm2axi4_lane
   import mm2axi4_pkg::*;
#(
   parameter int AXI4_DATALEN = 32
) (
   input  logic [31:0]               d,
   input  logic [3:0]                be,
   input  logic [1:0]                wr_lane,
   input  logic [1:0]                rd_lane,
   input  logic [AXI4_DATALEN-1:0]   rdata,
   output logic [AXI4_DATALEN-1:0]   wdata,
   output logic [AXI4_DATALEN/8-1:0] wstrb,
   output logic [31:0]               rword
);
   localparam int NL    = 1 << lane_bits(AXI4_DATALEN);
   localparam int STRBW = AXI4_DATALEN / 8;
   localparam logic [1:0] LMASK = 2'(NL - 1);

   logic [1:0] wl, rl;

   assign wl    = wr_lane & LMASK;
   assign rl    = rd_lane & LMASK;
   assign wdata = {NL{d}};
   assign wstrb = STRBW'(be) << (4 * wl);

   always_comb begin
      rword = '0;
      for (int i = 0; i < NL; i++) begin
         if (rl == 2'(i)) rword = rdata[32*i +: 32];
      end
   end

endmodule

// File: rtl/mm2axi4_bridge.sv
// Single-beat CPU-bus to AXI4 manager bridge (IDLE/RD/WR/DONE).
// Optional transaction timeout enabled by defining MM2AXI4_TIMEOUT_EN.
module mm2axi4_bridge
   import mm2axi4_pkg::*;
#(
   parameter int AXI4_IDLEN     = 12,
   parameter int AXI4_ADDRLEN   = 32,
   parameter int AXI4_DATALEN   = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               a,
   input  logic [31:0]               d,
   input  logic [3:0]                be,
   input  logic                      we,
   input  logic                      rd,
   output logic [31:0]               spo,
   output logic                      ready,
   output logic                      err,
   output logic                      irq,
   output logic [AXI4_IDLEN-1:0]     m_axi_awid,
   output logic [AXI4_ADDRLEN-1:0]   m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic                      m_axi_awlock,
   output logic [3:0]                m_axi_awcache,
   output logic [2:0]                m_axi_awprot,
   output logic [3:0]                m_axi_awqos,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [AXI4_DATALEN-1:0]   m_axi_wdata,
   output logic [AXI4_DATALEN/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [AXI4_IDLEN-1:0]     m_axi_bid,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [AXI4_IDLEN-1:0]     m_axi_arid,
   output logic [AXI4_ADDRLEN-1:0]   m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI4_IDLEN-1:0]     m_axi_rid,
   input  logic [AXI4_DATALEN-1:0]   m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);
   localparam int STRBW = AXI4_DATALEN / 8;

   state_t                    state, state_nx;
   logic [1:0]                lane_q;
   logic [AXI4_DATALEN-1:0]   wdata_c;
   logic [STRBW-1:0]          wstrb_c;
   logic [31:0]               rword;
   logic [AXI4_ADDRLEN-1:0]   addr_c;
   logic                      rd_fin, wr_fin, tmo;
   logic                      unused_ok;

   assign m_axi_awid    = '0;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = SIZE_4B;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = CACHE_BUF_MOD;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_arid    = '0;
   assign m_axi_arlen   = 8'd0;
   assign m_axi_arsize  = SIZE_4B;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = CACHE_BUF_MOD;
   assign m_axi_arprot  = 3'd0;
   assign m_axi_arqos   = 4'd0;
   assign m_axi_wlast   = m_axi_wvalid;

   assign ready  = (state == IDLE) & ~(we | rd);
   assign addr_c = AXI4_ADDRLEN'({a[31:2], 2'b00});
   assign rd_fin = (state == RD) & m_axi_rvalid & m_axi_rready;
   // B counts only when AW and W are done, including handshakes in this same cycle.
   assign wr_fin = (state == WR) & m_axi_bvalid & m_axi_bready
                 & (~m_axi_awvalid | m_axi_awready) & (~m_axi_wvalid | m_axi_wready);
   assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_rlast, a[1:0], (TIMEOUT_CYCLES > 0)};

   mm2axi4_lane #(.AXI4_DATALEN(AXI4_DATALEN)) u_lane (
      .d       (d),
      .be      (be),
      .wr_lane (a[3:2]),
      .rd_lane (lane_q),
      .rdata   (m_axi_rdata),
      .wdata   (wdata_c),
      .wstrb   (wstrb_c),
      .rword   (rword)
   );

`ifdef MM2AXI4_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                cnt <= '0;
      else if (state == IDLE && (rd || we))   cnt <= '0;
      else if (state == RD || state == WR)    cnt <= cnt + 1'b1;
   end

   assign tmo = (state == RD || state == WR) && (cnt == CW'(TIMEOUT_CYCLES - 1)) && !rd_fin && !wr_fin;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rd) state_nx = RD; else if (we) state_nx = WR;
         RD:      if (rd_fin || tmo) state_nx = DONE;
         WR:      if (wr_fin || tmo) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_araddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         lane_q        <= 2'd0;
         spo           <= 32'd0;
         err           <= 1'b0;
         irq           <= 1'b0;
      end else begin
         irq <= 1'b0;
         case (state)
            IDLE: begin
               if (rd) begin
                  m_axi_arvalid <= 1'b1;
                  m_axi_rready  <= 1'b1;
                  m_axi_araddr  <= addr_c;
                  lane_q        <= a[3:2];
                  err           <= 1'b0;
               end else if (we) begin
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_bready  <= 1'b1;
                  m_axi_awaddr  <= addr_c;
                  m_axi_wdata   <= wdata_c;
                  m_axi_wstrb   <= wstrb_c;
                  err           <= 1'b0;
               end
            end
            RD: begin
               m_axi_arvalid <= m_axi_arvalid & ~m_axi_arready;
               if (rd_fin) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b0;
                  spo           <= rword;
                  err           <= is_err(m_axi_rresp);
                  irq           <= is_err(m_axi_rresp);
               end else if (tmo) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b0;
                  spo           <= 32'hFFFF_FFFF;
                  err           <= 1'b1;
                  irq           <= 1'b1;
               end
            end
            WR: begin
               m_axi_awvalid <= m_axi_awvalid & ~m_axi_awready;
               m_axi_wvalid  <= m_axi_wvalid & ~m_axi_wready;
               if (wr_fin) begin
                  m_axi_bready <= 1'b0;
                  err          <= is_err(m_axi_bresp);
                  irq          <= is_err(m_axi_bresp);
               end else if (tmo) begin
                  m_axi_awvalid <= 1'b0;
                  m_axi_wvalid  <= 1'b0;
                  m_axi_bready  <= 1'b0;
                  err           <= 1'b1;
                  irq           <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mm2axi4_bridge.sv
// Self-checking bench for mm2axi4_bridge with a 128-bit data bus and a configurable AXI slave.
module tb_mm2axi4_bridge;
   localparam int DW = 128;

   logic clk, rst;
   logic [31:0] a, d, spo;
   logic [3:0]  be;
   logic we, rd, ready, err, irq;
   logic [11:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [31:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic        m_axi_awlock, m_axi_arlock;
   logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
   logic [DW/8-1:0] m_axi_wstrb;

   mm2axi4_bridge #(.AXI4_IDLEN(12), .AXI4_ADDRLEN(32), .AXI4_DATALEN(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .a(a), .d(d), .be(be), .we(we), .rd(rd),
      .spo(spo), .ready(ready), .err(err), .irq(irq),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
   int aw_wait, w_wait, ar_wait, r_wait;
   bit aw_seen, w_seen, ar_seen;
   bit b_early = 0, slv_dead = 0;
   logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
   logic [31:0] r_words [4];

   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rid = 0; m_axi_rlast = 0;
      m_axi_rdata = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      forever begin
         @(posedge clk); #1;
         if (!m_axi_bready) begin aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0; end
         if (!m_axi_rready) begin ar_seen = 0; ar_wait = 0; r_wait = 0; end
         m_axi_awready = !slv_dead && m_axi_awvalid && aw_wait >= aw_lat;
         if (m_axi_awvalid && !m_axi_awready) aw_wait++;
         if (m_axi_awvalid && m_axi_awready) aw_seen = 1;
         m_axi_wready = !slv_dead && m_axi_wvalid && w_wait >= w_lat;
         if (m_axi_wvalid && !m_axi_wready) w_wait++;
         if (m_axi_wvalid && m_axi_wready) w_seen = 1;
         m_axi_bvalid = !slv_dead && m_axi_bready && (b_early || (aw_seen && w_seen));
         m_axi_bresp  = b_resp;
         m_axi_arready = !slv_dead && m_axi_arvalid && ar_wait >= ar_lat;
         if (m_axi_arvalid && !m_axi_arready) ar_wait++;
         if (m_axi_arvalid && m_axi_arready) ar_seen = 1;
         m_axi_rvalid = !slv_dead && m_axi_rready && ar_seen && r_wait >= r_lat;
         if (m_axi_rready && ar_seen && !m_axi_rvalid) r_wait++;
         m_axi_rresp = r_resp;
         m_axi_rlast = m_axi_rvalid;
         m_axi_rdata = {r_words[3], r_words[2], r_words[1], r_words[0]};
      end
   end

   // ---------------- monitor ----------------
   int irq_cnt, aw_cyc, ar_cyc, bready_cyc, const_bad = 0;
   logic [31:0]     mon_awaddr, mon_araddr;
   logic [DW-1:0]   mon_wdata;
   logic [DW/8-1:0] mon_wstrb;

   task automatic clr_mon();
      irq_cnt = 0; aw_cyc = 0; ar_cyc = 0; bready_cyc = 0;
   endtask

   initial begin
      clr_mon();
      forever begin
         @(negedge clk);
         if (irq) irq_cnt++;
         if (m_axi_bready) bready_cyc++;
         if (m_axi_awvalid) begin
            aw_cyc++; mon_awaddr = m_axi_awaddr;
            if (m_axi_awid != 0 || m_axi_awlen != 0 || m_axi_awsize != 3'b010 || m_axi_awburst != 2'b01 ||
                m_axi_awlock || m_axi_awcache != 4'b0011 || m_axi_awprot != 0 || m_axi_awqos != 0) const_bad++;
         end
         if (m_axi_wvalid) begin
            mon_wdata = m_axi_wdata; mon_wstrb = m_axi_wstrb;
            if (!m_axi_wlast) const_bad++;
         end
         if (m_axi_arvalid) begin
            ar_cyc++; mon_araddr = m_axi_araddr;
            if (m_axi_arid != 0 || m_axi_arlen != 0 || m_axi_arsize != 3'b010 || m_axi_arburst != 2'b01 ||
                m_axi_arlock || m_axi_arcache != 4'b0011 || m_axi_arprot != 0 || m_axi_arqos != 0) const_bad++;
         end
      end
   end

   // ---------------- CPU-side driver ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic start_req(input bit is_rd, input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] dat, input logic [3:0] b);
      clr_mon();
      a = addr; d = dat; be = b; rd = is_rd; we = is_wr;
      tick();
      rd = 0; we = 0;
   endtask

   task automatic wait_ready(input int budget, output int lat);
      lat = 1;
      while (!ready && lat < budget) begin tick(); lat++; end
   endtask

   // Reference rules for lane steering, written per bit/lane.
   function automatic logic [DW/8-1:0] exp_strb(input logic [3:0] b, input int lane);
      logic [DW/8-1:0] s = '0;
      for (int i = 0; i < DW/8; i++) if (i / 4 == lane) s[i] = b[i % 4];
      return s;
   endfunction

   function automatic logic [DW-1:0] exp_wdat(input logic [31:0] v);
      logic [DW-1:0] w;
      for (int i = 0; i < DW/32; i++) w[32*i +: 32] = v;
      return w;
   endfunction

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] dat;
      logic [3:0]  b;
      logic [1:0]  resp;
      int          l0, l1;
      logic [31:0] e_spo;
      logic [15:0] e_strb;
      bit          e_err;
      int          e_lat;
   } vec_t;

   vec_t tbl [6];

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      aw_lat = v.l0; ar_lat = v.l0; w_lat = v.l1; r_lat = v.l1;
      r_resp = v.resp; b_resp = v.resp;
      start_req(v.is_rd, !v.is_rd, v.addr, v.dat, v.b);
      wait_ready(40, lat);
      chk({tag, ".lat"}, 128'(lat), 128'(v.e_lat));
      chk({tag, ".err"}, 128'(err), 128'(v.e_err));
      chk({tag, ".irq"}, 128'(irq_cnt), 128'(v.e_err));
      if (v.is_rd) begin
         chk({tag, ".araddr"}, 128'(mon_araddr), 128'({v.addr[31:2], 2'b00}));
         chk({tag, ".spo"}, 128'(spo), 128'(v.e_spo));
      end else begin
         chk({tag, ".awaddr"}, 128'(mon_awaddr), 128'({v.addr[31:2], 2'b00}));
         chk({tag, ".wstrb"}, 128'(mon_wstrb), 128'(v.e_strb));
         chk({tag, ".wdata"}, mon_wdata, exp_wdat(v.dat));
      end
   endtask

   initial begin
      int lat;
      logic [31:0] model_spo;
      rst = 1; a = 0; d = 0; be = 0; we = 0; rd = 0;
      r_words[0] = 32'h1111_1111; r_words[1] = 32'h2222_2222;
      r_words[2] = 32'h3333_3333; r_words[3] = 32'h4444_4444;

      // reset state
      #12;
      chk("rst.ready", 128'(ready), 128'(1));
      chk("rst.valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_wlast}), 128'(0));
      chk("rst.status", 128'({spo, err, irq}), 128'(0));
      chk("rst.regs", 128'({m_axi_awaddr, m_axi_araddr}), 128'(0));
      chk("rst.wdata", m_axi_wdata, 128'(0));
      @(negedge clk); rst = 0;
      tick();

      // directed vectors
      tbl[0] = '{1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 2'b00, 0, 0, 32'h0, 16'h0030, 1'b0, 3};
      tbl[1] = '{1'b1, 32'h0000_2008, 32'h0,         4'b0000, 2'b00, 0, 0, 32'h3333_3333, 16'h0, 1'b0, 3};
      tbl[2] = '{1'b1, 32'h0000_300C, 32'h0,         4'b0000, 2'b10, 0, 0, 32'h4444_4444, 16'h0, 1'b1, 3};
      tbl[3] = '{1'b0, 32'h0000_0000, 32'h0123_4567, 4'b1111, 2'b11, 2, 1, 32'h0, 16'h000F, 1'b1, 5};
      tbl[4] = '{1'b1, 32'h0000_4004, 32'h0,         4'b0000, 2'b01, 1, 2, 32'h2222_2222, 16'h0, 1'b0, 6};
      tbl[5] = '{1'b0, 32'h1000_0008, 32'hCAFE_F00D, 4'b1000, 2'b00, 0, 3, 32'h0, 16'h0800, 1'b0, 6};
      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // randomized transactions against the reference rules
      model_spo = 32'h2222_2222;
      for (int i = 0; i < 60; i++) begin
         vec_t v;
         int lane;
         v.is_rd = 1'($urandom_range(0, 1));
         v.addr  = $urandom() & 32'hFFFF_FFFC;
         v.dat   = $urandom();
         v.b     = 4'($urandom_range(0, 15));
         v.resp  = 2'($urandom_range(0, 3));
         v.l0    = $urandom_range(0, 3);
         v.l1    = $urandom_range(0, 3);
         b_early = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) r_words[k] = $urandom();
         lane    = int'(v.addr[3:2]);
         if (v.is_rd) model_spo = r_words[lane];
         v.e_spo  = model_spo;
         v.e_strb = exp_strb(v.b, lane);
         v.e_err  = (v.resp >= 2'd2);
         v.e_lat  = v.is_rd ? 3 + v.l0 + v.l1 : 3 + ((v.l0 > v.l1) ? v.l0 : v.l1);
         run_vec(v, $sformatf("rnd%0d", i));
         if (!v.is_rd) chk($sformatf("rnd%0d.spo_hold", i), 128'(spo), 128'(model_spo));
      end
      b_early = 0;

      // error read, then the next accepted request clears err
      aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0; r_resp = 2'b10; b_resp = 2'b00;
      start_req(1, 0, 32'h40, 0, 0);
      wait_ready(40, lat);
      chk("errclr.set", 128'(err), 128'(1));
      chk("errclr.irq", 128'(irq_cnt), 128'(1));
      r_resp = 2'b00;
      start_req(0, 1, 32'h44, 32'h5555_AAAA, 4'hF);
      chk("errclr.cleared", 128'(err), 128'(0));
      wait_ready(40, lat);
      chk("errclr.after", 128'(err), 128'(0));

      // rd and we together: read wins, write dropped
      r_words[1] = 32'hABCD_0001;
      start_req(1, 1, 32'h104, 32'h9999_9999, 4'hF);
      wait_ready(40, lat);
      chk("both.lat", 128'(lat), 128'(3));
      chk("both.aw", 128'(aw_cyc), 128'(0));
      chk("both.ar", 128'(ar_cyc), 128'(1));
      chk("both.spo", 128'(spo), 128'(32'hABCD_0001));

      // W handshakes 5 cycles before AW while B is raised early
      aw_lat = 5; w_lat = 0; b_early = 1;
      start_req(0, 1, 32'h200, 32'h7777_7777, 4'hF);
      wait_ready(40, lat);
      chk("early_b.lat", 128'(lat), 128'(8));
      chk("early_b.bready", 128'(bready_cyc), 128'(6));
      repeat (5) tick();
      chk("early_b.once", 128'(bready_cyc), 128'(6));
      chk("early_b.idle", 128'(ready), 128'(1));
      aw_lat = 0; b_early = 0;

      // read to an unresponsive slave
      slv_dead = 1;
      start_req(1, 0, 32'h300, 0, 0);
      wait_ready(40, lat);
`ifdef MM2AXI4_TIMEOUT_EN
      chk("tmo.lat", 128'(lat), 128'(18));
      chk("tmo.spo", 128'(spo), 128'(32'hFFFF_FFFF));
      chk("tmo.err", 128'(err), 128'(1));
      chk("tmo.irq", 128'(irq_cnt), 128'(1));
      chk("tmo.valids", 128'({m_axi_arvalid, m_axi_rready}), 128'(0));
`else
      chk("hang.ready", 128'(ready), 128'(0));
      chk("hang.valids", 128'({m_axi_arvalid, m_axi_rready}), 128'(2'b11));
`endif
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      tick();

      // asynchronous reset in the middle of a write
      start_req(0, 1, 32'h400, 32'h1234_5678, 4'hF);
      repeat (2) tick();
      chk("arst.pre", 128'(m_axi_awvalid), 128'(1));
      @(negedge clk); #2 rst = 1;
      #1;
      chk("arst.valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 128'(0));
      @(negedge clk); rst = 0;
      #1;
      chk("arst.ready", 128'(ready), 128'(1));
      slv_dead = 0;
      tick();
      r_words[2] = 32'h0BAD_CAFE;
      start_req(1, 0, 32'h508, 0, 0);
      wait_ready(40, lat);
      chk("arst.recover_lat", 128'(lat), 128'(3));
      chk("arst.recover_spo", 128'(spo), 128'(32'h0BAD_CAFE));

      chk("axi.const_fields", 128'(const_bad), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
